// File: rtl/connect_enable_ctrl.sv
// Compression-enable controller for CONNECT: counts outstanding AXI traffic and
// switches ENABLE_o only after stalling address issue and draining in-flight bursts.
module connect_enable_ctrl #(
    parameter int OT_W       = 6,
    parameter int SETTLE_CYC = 2,
    parameter int DRAIN_TO   = 1024
) (
    input  logic            CLK_i,
    input  logic            RSTN_i,
    input  logic            ENABLE_REQ_i,
    input  logic            ARVALID_i,
    input  logic            ARREADY_i,
    input  logic            AWVALID_i,
    input  logic            AWREADY_i,
    input  logic            WVALID_i,
    input  logic            WREADY_i,
    input  logic            WLAST_i,
    input  logic            RVALID_i,
    input  logic            RREADY_i,
    input  logic            RLAST_i,
    input  logic            BVALID_i,
    input  logic            BREADY_i,
    input  logic            ERR_CLR_i,
    output logic            ENABLE_o,
    output logic            HOLD_o,
    output logic            BUSY_o,
    output logic            ERR_o,
    output logic [OT_W-1:0] RD_OT_o,
    output logic [OT_W-1:0] WR_OT_o
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ON     = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [16:0]      DRAIN_TO_W  = 17'(DRAIN_TO);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC);
    localparam logic [OT_W:0]    WP_MAX      = {1'b0, {OT_W{1'b1}}};
    localparam logic [OT_W:0]    WP_MIN      = {1'b1, {OT_W{1'b0}}};

    // Reset asserts asynchronously but is released on a clock edge.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_t                  state_q, state_d;
    logic                    enable_q, enable_d;
    logic                    target_q, target_d;
    logic                    hold_q, hold_d;
    logic                    err_q, err_d;
    logic [15:0]             timer_q, timer_d;
    logic [3:0]              settle_q, settle_d;
    logic [OT_W-1:0]         rd_ot_q, rd_ot_d;
    logic [OT_W-1:0]         wr_ot_q, wr_ot_d;
    logic signed [OT_W:0]    w_pend_q, w_pend_d;

    logic hs_ar, hs_aw, hs_wl, hs_rl, hs_b;
    logic quiescent;
    logic rd_err, wr_err, wp_err, drain_err;
    logic [OT_W:0] rd_step, wr_step;
    logic [16:0]   timer_inc;

    assign hs_ar = ARVALID_i & ARREADY_i;
    assign hs_aw = AWVALID_i & AWREADY_i;
    assign hs_wl = WVALID_i & WREADY_i & WLAST_i;
    assign hs_rl = RVALID_i & RREADY_i & RLAST_i;
    assign hs_b  = BVALID_i & BREADY_i;

    // Returns {error, next_count}; simultaneous inc and dec cancel out.
    function automatic logic [OT_W:0] ot_step(input logic [OT_W-1:0] cnt,
                                              input logic inc, input logic dec);
        logic [OT_W:0] r;
        r = {1'b0, cnt};
        if (inc && !dec) begin
            if (&cnt) r[OT_W] = 1'b1;
            else      r = {1'b0, cnt + OT_W'(1)};
        end else if (!inc && dec) begin
            if (cnt == '0) r[OT_W] = 1'b1;
            else           r = {1'b0, cnt - OT_W'(1)};
        end
        return r;
    endfunction

    assign rd_step = ot_step(rd_ot_q, hs_ar, hs_rl);
    assign wr_step = ot_step(wr_ot_q, hs_aw, hs_b);
    assign rd_ot_d = rd_step[OT_W-1:0];
    assign wr_ot_d = wr_step[OT_W-1:0];
    assign rd_err  = rd_step[OT_W];
    assign wr_err  = wr_step[OT_W];

    // W data may lead its AW, so this balance is allowed to go negative.
    always_comb begin
        w_pend_d = w_pend_q;
        wp_err   = 1'b0;
        if (hs_aw && !hs_wl) begin
            if (w_pend_q == $signed(WP_MAX)) wp_err = 1'b1;
            else                             w_pend_d = w_pend_q + (OT_W+1)'(1);
        end else if (!hs_aw && hs_wl) begin
            if (w_pend_q == $signed(WP_MIN)) wp_err = 1'b1;
            else                             w_pend_d = w_pend_q - (OT_W+1)'(1);
        end
    end

    assign quiescent = (rd_ot_q == '0) && (wr_ot_q == '0) && (w_pend_q == '0) &&
                       !(hs_ar | hs_aw | hs_wl | hs_rl | hs_b);

    assign timer_inc = {1'b0, timer_q} + 17'd1;

    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        target_d  = target_q;
        timer_d   = timer_q;
        settle_d  = settle_q;
        drain_err = 1'b0;
        case (state_q)
            ST_OFF, ST_ON: begin
                if (ENABLE_REQ_i != enable_q) begin
                    target_d = ENABLE_REQ_i;
                    timer_d  = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                timer_d = timer_inc[15:0];
                if (ENABLE_REQ_i == enable_q) begin
                    state_d = enable_q ? ST_ON : ST_OFF;
                end else if (quiescent) begin
                    enable_d = target_q;
                    settle_d = SETTLE_INIT;
                    state_d  = ST_SETTLE;
                end else if (timer_inc >= DRAIN_TO_W) begin
                    // Abort; a request still pending re-enters DRAIN from the steady state.
                    drain_err = 1'b1;
                    state_d   = enable_q ? ST_ON : ST_OFF;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = enable_q ? ST_ON : ST_OFF;
                else                settle_d = settle_q - 4'd1;
            end
            default: state_d = ST_OFF;
        endcase
    end

    assign hold_d = (state_d == ST_DRAIN) || (state_d == ST_SETTLE);
    assign err_d  = rd_err | wr_err | wp_err | drain_err | (err_q & ~ERR_CLR_i);

    always_ff @(posedge CLK_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q  <= ST_OFF;
            enable_q <= 1'b0;
            target_q <= 1'b0;
            hold_q   <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= '0;
            settle_q <= '0;
            rd_ot_q  <= '0;
            wr_ot_q  <= '0;
            w_pend_q <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            target_q <= target_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
            rd_ot_q  <= rd_ot_d;
            wr_ot_q  <= wr_ot_d;
            w_pend_q <= w_pend_d;
        end
    end

    assign ENABLE_o = enable_q;
    assign HOLD_o   = hold_q;
    assign BUSY_o   = (state_q == ST_DRAIN) || (state_q == ST_SETTLE);
    assign ERR_o    = err_q;
    assign RD_OT_o  = rd_ot_q;
    assign WR_OT_o  = wr_ot_q;

endmodule

// File: tb/tb_connect_enable_ctrl.sv
// Directed bench for connect_enable_ctrl: a cycle-level behavioural model is
// compared every cycle, plus hand-computed literal checks along each scenario.
module tb_connect_enable_ctrl;

    localparam int OT_W       = 6;
    localparam int SETTLE_CYC = 2;
    localparam int DRAIN_TO   = 16;
    localparam int MAXC       = (1 << OT_W) - 1;

    logic clk, rstn, req, clr;
    logic arv, arr, awv, awr, wv, wr, wlast, rv, rr, rlast, bv, br;
    logic en_o, hold_o, busy_o, err_o;
    logic [OT_W-1:0] rd_ot_o, wr_ot_o;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_on   = 0;

    connect_enable_ctrl #(
        .OT_W(OT_W), .SETTLE_CYC(SETTLE_CYC), .DRAIN_TO(DRAIN_TO)
    ) dut (
        .CLK_i(clk), .RSTN_i(rstn), .ENABLE_REQ_i(req),
        .ARVALID_i(arv), .ARREADY_i(arr), .AWVALID_i(awv), .AWREADY_i(awr),
        .WVALID_i(wv), .WREADY_i(wr), .WLAST_i(wlast),
        .RVALID_i(rv), .RREADY_i(rr), .RLAST_i(rlast),
        .BVALID_i(bv), .BREADY_i(br), .ERR_CLR_i(clr),
        .ENABLE_o(en_o), .HOLD_o(hold_o), .BUSY_o(busy_o), .ERR_o(err_o),
        .RD_OT_o(rd_ot_o), .WR_OT_o(wr_ot_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Counts are plain integers clamped to their legal range; mode switching is
    // tracked as a phase plus absolute cycle deadlines derived from the latencies.
    int m_rd = 0, m_wr = 0, m_wp = 0;
    int m_cyc = 0, m_drain_start = 0, m_release_at = 0;
    int m_phase = 0;            // 0 steady, 1 draining, 2 settling
    bit m_en = 0, m_err = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_rd = 0; m_wr = 0; m_wp = 0;
            m_phase = 0; m_en = 0; m_err = 0;
        end else begin
            bit h_ar, h_aw, h_wl, h_rl, h_b, quiet, e;
            h_ar = arv & arr;
            h_aw = awv & awr;
            h_wl = wv & wr & wlast;
            h_rl = rv & rr & rlast;
            h_b  = bv & br;
            quiet = (m_rd == 0) && (m_wr == 0) && (m_wp == 0) &&
                    !(h_ar || h_aw || h_wl || h_rl || h_b);
            e = 0;
            m_rd = m_rd + int'(h_ar) - int'(h_rl);
            if (m_rd > MAXC) begin m_rd = MAXC; e = 1; end
            if (m_rd < 0)    begin m_rd = 0;    e = 1; end
            m_wr = m_wr + int'(h_aw) - int'(h_b);
            if (m_wr > MAXC) begin m_wr = MAXC; e = 1; end
            if (m_wr < 0)    begin m_wr = 0;    e = 1; end
            m_wp = m_wp + int'(h_aw) - int'(h_wl);
            if (m_wp > MAXC)       begin m_wp = MAXC;       e = 1; end
            if (m_wp < -(MAXC+1))  begin m_wp = -(MAXC+1);  e = 1; end
            case (m_phase)
                0: if (req != m_en) begin
                       m_phase = 1;
                       m_drain_start = m_cyc + 1;
                   end
                1: if (req == m_en) m_phase = 0;
                   else if (quiet) begin
                       m_en = ~m_en;
                       m_phase = 2;
                       // toggle visible next cycle; release SETTLE_CYC+1 after that
                       m_release_at = m_cyc + SETTLE_CYC + 2;
                   end else if (m_cyc - m_drain_start + 1 >= DRAIN_TO) begin
                       e = 1;
                       m_phase = 0;
                   end
                default: if (m_cyc + 1 >= m_release_at) m_phase = 0;
            endcase
            m_err = e || (m_err && !clr);
        end
        if (rstn) m_cyc = m_cyc + 1;
    end

    task automatic cmp(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("model.ENABLE_o", int'(en_o),   int'(m_en));
            cmp("model.HOLD_o",   int'(hold_o), int'(m_phase != 0));
            cmp("model.BUSY_o",   int'(busy_o), int'(m_phase != 0));
            cmp("model.ERR_o",    int'(err_o),  int'(m_err));
            cmp("model.RD_OT_o",  int'(rd_ot_o), m_rd);
            cmp("model.WR_OT_o",  int'(wr_ot_o), m_wr);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string name, input int got, input int exp);
        cmp(name, got, exp);
        if (got == exp) $display("check %s: ok (%0d)", name, got);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        arv = 0; arr = 0; awv = 0; awr = 0; wv = 0; wr = 0; wlast = 0;
        rv = 0; rr = 0; rlast = 0; bv = 0; br = 0; clr = 0;
    endtask

    task automatic do_ar();  idle(); arv = 1; arr = 1; endtask
    task automatic do_rl();  idle(); rv = 1; rr = 1; rlast = 1; endtask
    task automatic do_aw();  idle(); awv = 1; awr = 1; endtask
    task automatic do_wl();  idle(); wv = 1; wr = 1; wlast = 1; endtask
    task automatic do_b();   idle(); bv = 1; br = 1; endtask

    initial begin
        rstn = 1; req = 0; idle();
        #2 rstn = 0;
        tick(2);
        rstn = 1;
        tick(4);
        chk_on = 1;
        lit("reset.ENABLE", int'(en_o), 0);
        lit("reset.HOLD",   int'(hold_o), 0);
        lit("reset.ERR",    int'(err_o), 0);
        lit("reset.RD_OT",  int'(rd_ot_o), 0);

        // S1: idle switch OFF->ON
        req = 1;
        tick(1); lit("s1.c1.HOLD", int'(hold_o), 1); lit("s1.c1.ENABLE", int'(en_o), 0);
                 lit("s1.c1.BUSY", int'(busy_o), 1);
        tick(1); lit("s1.c2.ENABLE", int'(en_o), 1);
        tick(2); lit("s1.c4.HOLD", int'(hold_o), 1); lit("s1.c4.BUSY", int'(busy_o), 1);
        tick(1); lit("s1.c5.HOLD", int'(hold_o), 0); lit("s1.c5.BUSY", int'(busy_o), 0);
                 lit("s1.c5.ENABLE", int'(en_o), 1);

        // back to OFF, then S2: three reads drain before ON
        req = 0;
        tick(6); lit("s2.pre.ENABLE", int'(en_o), 0); lit("s2.pre.HOLD", int'(hold_o), 0);
        do_ar(); tick(3); idle();
        lit("s2.RD_OT3", int'(rd_ot_o), 3);
        req = 1;
        tick(1); lit("s2.HOLD", int'(hold_o), 1);
        tick(1); lit("s2.ENABLE_wait", int'(en_o), 0);
        do_rl(); tick(1); idle(); lit("s2.RD_OT2", int'(rd_ot_o), 2);
        tick(1);
        do_rl(); tick(1); idle(); lit("s2.RD_OT1", int'(rd_ot_o), 1);
        do_rl(); tick(1); idle(); lit("s2.RD_OT0", int'(rd_ot_o), 0);
                 lit("s2.ENABLE_last", int'(en_o), 0);
        tick(1); lit("s2.ENABLE_on", int'(en_o), 1);
        tick(2); lit("s2.HOLD_settle", int'(hold_o), 1);
        tick(1); lit("s2.HOLD_rel", int'(hold_o), 0);

        // S3: ON->OFF, WLAST leads its AW by two cycles, then B
        req = 0;
        tick(1); lit("s3.HOLD", int'(hold_o), 1);
        do_wl(); tick(1); idle(); lit("s3.after_wl.ENABLE", int'(en_o), 1);
        tick(1);
        do_aw(); tick(1); idle(); lit("s3.WR_OT1", int'(wr_ot_o), 1);
                 lit("s3.after_aw.ENABLE", int'(en_o), 1);
        tick(1);
        do_b(); tick(1); idle(); lit("s3.WR_OT0", int'(wr_ot_o), 0);
                 lit("s3.after_b.ENABLE", int'(en_o), 1);
        tick(1); lit("s3.ENABLE_off", int'(en_o), 0); lit("s3.ERR", int'(err_o), 0);
        tick(3); lit("s3.HOLD_rel", int'(hold_o), 0);

        // S4: request pulse withdrawn while a read is outstanding
        do_ar(); tick(1); idle();
        req = 1; tick(1); lit("s4.HOLD", int'(hold_o), 1);
        req = 0; tick(1); lit("s4.HOLD_drop", int'(hold_o), 0);
                 lit("s4.ENABLE", int'(en_o), 0); lit("s4.BUSY", int'(busy_o), 0);
        do_rl(); tick(1); idle(); lit("s4.RD_OT0", int'(rd_ot_o), 0);

        // S5: drain timeout with a stuck read, then retry and error clear
        do_ar(); tick(1); idle();
        req = 1;
        tick(1);  lit("s5.c1.HOLD", int'(hold_o), 1);
        tick(15); lit("s5.c16.HOLD", int'(hold_o), 1); lit("s5.c16.ERR", int'(err_o), 0);
        tick(1);  lit("s5.c17.ERR", int'(err_o), 1); lit("s5.c17.HOLD", int'(hold_o), 0);
                  lit("s5.c17.ENABLE", int'(en_o), 0);
        tick(1);  lit("s5.c18.retry", int'(hold_o), 1);
        req = 0; do_b(); clr = 1;
        tick(1); idle(); lit("s5.clr_vs_new.ERR", int'(err_o), 1);
                 lit("s5.WR_OT", int'(wr_ot_o), 0); lit("s5.withdraw.HOLD", int'(hold_o), 0);
        clr = 1; tick(1); idle(); lit("s5.clr.ERR", int'(err_o), 0);
        do_rl(); tick(1); idle(); lit("s5.RD_OT0", int'(rd_ot_o), 0);

        // S6: read counter saturation and underflow
        do_ar(); tick(MAXC + 1); idle();
        lit("s6.sat.RD_OT", int'(rd_ot_o), MAXC); lit("s6.sat.ERR", int'(err_o), 1);
        do_ar(); rv = 1; rr = 1; rlast = 1; clr = 1;
        tick(1); idle(); lit("s6.incdec.RD_OT", int'(rd_ot_o), MAXC);
                 lit("s6.incdec.ERR", int'(err_o), 0);
        do_rl(); tick(MAXC); idle(); lit("s6.drain.RD_OT", int'(rd_ot_o), 0);
        do_rl(); tick(1); idle(); lit("s6.under.ERR", int'(err_o), 1);
                 lit("s6.under.RD_OT", int'(rd_ot_o), 0);
        clr = 1; tick(1); idle();

        // S7: reset during SETTLE with ENABLE_o=1
        req = 1;
        tick(2); lit("s7.ENABLE", int'(en_o), 1);
        do_ar(); tick(1); idle(); lit("s7.RD_OT", int'(rd_ot_o), 1);
                 lit("s7.settle.HOLD", int'(hold_o), 1);
        #2 rstn = 0; req = 0;
        #1;
        lit("s7.rst.ENABLE", int'(en_o), 0); lit("s7.rst.HOLD", int'(hold_o), 0);
        lit("s7.rst.RD_OT", int'(rd_ot_o), 0); lit("s7.rst.BUSY", int'(busy_o), 0);
        tick(2);
        rstn = 1;
        tick(4);
        do_b(); tick(1); idle(); lit("s7.b_under.ERR", int'(err_o), 1);
                 lit("s7.b_under.WR_OT", int'(wr_ot_o), 0);
        clr = 1; tick(1); idle(); lit("s7.clr.ERR", int'(err_o), 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
